onehot_lane_reg: RTL
====================

Name: onehot_lane_reg

Overview:
Registered, parametrised one-hot position holder for enemy lane/column selection; generalises plain unsigned-to-onehot encoding to arbitrary (non-power-of-two) widths.
- Holds a current position and presents it both as a one-hot vector and as an unsigned index.
- Supports absolute load and signed multi-step relative moves.
- Selectable wrap-around or saturating boundary mode.
- Sits between the enemy movement controller and the lane/sprite enable logic.

Parameters:
OUT_W, 8, number of one-hot positions; legal range 2..256, not required to be a power of two
WRAP, 1, boundary mode: 1 = moves wrap modulo OUT_W, 0 = moves saturate at 0 / OUT_W-1
RESET_IDX, 0, position after reset; must be < OUT_W
(localparam IDX_W = $clog2(OUT_W), width of every index/amount port)

Ports:
clk        input   1      system clock, all state on rising edge
reset      input   1      asynchronous, active-high reset
load       input   1      absolute load request this cycle
load_idx   input   IDX_W  target position for load
step       input   1      relative move request this cycle
step_dir   input   1      0 = toward higher index (left shift), 1 = toward lower index
step_amt   input   IDX_W  move distance; 0 = no motion
out        output  OUT_W  registered one-hot position
idx        output  IDX_W  registered unsigned position; out == 1 << idx at all times
edge_hit   output  1      one-cycle pulse: saturating move was clamped (WRAP=0 only)
bad_idx    output  1      one-cycle pulse: load rejected, load_idx >= OUT_W

Behaviour:
- Reset (async assert, sync-to-clk deassert handled upstream):
  - idx = RESET_IDX, out = 1 << RESET_IDX, edge_hit = 0, bad_idx = 0.
  - Reset mid-operation discards any load/step presented in the same cycle.
- Latency: all outputs registered; a request at edge N is visible after edge N; no combinational input-to-output paths.
- Priority per cycle: reset > load > step. With load and step both high, step is ignored entirely (no edge_hit).
- Load:
  - load_idx < OUT_W: idx <= load_idx.
  - load_idx >= OUT_W (possible only when OUT_W is not a power of two): position unchanged, bad_idx = 1 next cycle.
- Step, amt = step_amt mod OUT_W, computed at IDX_W+1 bits, no truncation before the comparison:
  - WRAP=1:
    - dir 0: new = (idx + amt) mod OUT_W.
    - dir 1: new = (idx + OUT_W - amt) mod OUT_W.
    - edge_hit never asserts.
  - WRAP=0 uses raw step_amt, not reduced:
    - dir 0: target = idx + step_amt; if target > OUT_W-1, new = OUT_W-1 and edge_hit = 1.
    - dir 1: if step_amt > idx, new = 0 and edge_hit = 1; else new = idx - step_amt.
    - Exactly reaching the edge is not a clamp: edge_hit = 0.
    - Already at the edge and stepping outward by a nonzero amount: stays, edge_hit = 1.
- step_amt == 0: no change, no pulse, in either mode.
- Pulses (edge_hit, bad_idx) are high for exactly the one cycle after the causing request; they return to 0 on the next edge unless re-caused.
- Invariant, checkable every cycle: $onehot(out), out == (1 << idx), idx < OUT_W.
- Idle (no load, no step): hold state, pulses low.

Test Plan:
1. OUT_W=5, WRAP=1, RESET_IDX=2; assert reset mid-run with load=1, load_idx=4 -> idx=2, out=5'b00100 immediately on reset, and still after release.
2. WRAP=1, OUT_W=5, idx=3; step dir0 amt=4 -> idx=2 (out=00100); then step dir1 amt=3 -> idx=4 (out=10000); step amt=0 -> unchanged; edge_hit stays 0 throughout.
3. WRAP=0, OUT_W=5, idx=3:
   - step dir0 amt=1 -> idx=4, edge_hit=0.
   - step dir0 amt=1 again -> idx=4, edge_hit=1 for one cycle.
   - then dir1 amt=7 -> idx=0, edge_hit=1.
4. OUT_W=5; load load_idx=6 -> idx unchanged, bad_idx=1 one cycle then 0; load load_idx=0 -> out=00001, bad_idx=0.
5. load=1 load_idx=1 together with step=1 dir0 amt=2 -> idx=1 (load wins, no edge_hit).
6. OUT_W=8, WRAP=1: 200 cycles of random load/step/amt -> bench scoreboard matches the index model every cycle, and the one-hot invariant holds throughout.

Source files
------------

// File: rtl/onehot_lane_reg.sv
// Registered one-hot lane/column position with absolute load and signed relative moves.
// Works for any width 2..256; moves either wrap modulo OUT_W or saturate at the ends.
module onehot_lane_reg #(
   parameter int OUT_W     = 8,
   parameter bit WRAP      = 1'b1,
   parameter int RESET_IDX = 0,
   localparam int IDX_W    = $clog2(OUT_W)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [IDX_W-1:0] load_idx,
   input  logic             step,
   input  logic             step_dir,
   input  logic [IDX_W-1:0] step_amt,
   output logic [OUT_W-1:0] out,
   output logic [IDX_W-1:0] idx,
   output logic             edge_hit,
   output logic             bad_idx
);

   // One extra bit keeps idx + amt and idx + OUT_W - amt exact for every legal width.
   localparam logic [IDX_W:0]   W_X    = (IDX_W + 1)'(OUT_W);
   localparam logic [IDX_W:0]   MAX_X  = (IDX_W + 1)'(OUT_W - 1);
   localparam logic [IDX_W-1:0] RST_I  = IDX_W'(RESET_IDX);
   localparam logic [OUT_W-1:0] RST_OH = OUT_W'(1) << RESET_IDX;

   logic [IDX_W:0]   idx_x;
   logic [IDX_W:0]   amt_x;
   logic [IDX_W:0]   amt_mod;
   logic [IDX_W:0]   sum_x;
   logic [IDX_W:0]   next_x;
   logic [IDX_W-1:0] idx_d;
   logic [OUT_W-1:0] out_d;
   logic             edge_d;
   logic             bad_d;

   always_comb begin
      idx_x   = {1'b0, idx};
      amt_x   = {1'b0, step_amt};
      // step_amt < 2*OUT_W, so a single conditional subtract is a full modulo.
      amt_mod = (amt_x >= W_X) ? (amt_x - W_X) : amt_x;
      sum_x   = '0;
      next_x  = idx_x;
      edge_d  = 1'b0;
      bad_d   = 1'b0;

      if (load) begin
         if ({1'b0, load_idx} < W_X) begin
            next_x = {1'b0, load_idx};
         end else begin
            bad_d = 1'b1;
         end
      end else if (step && (step_amt != '0)) begin
         if (WRAP) begin
            if (!step_dir) begin
               sum_x  = idx_x + amt_mod;
               next_x = (sum_x >= W_X) ? (sum_x - W_X) : sum_x;
            end else begin
               next_x = (amt_mod > idx_x) ? (idx_x + W_X - amt_mod) : (idx_x - amt_mod);
            end
         end else begin
            if (!step_dir) begin
               sum_x = idx_x + amt_x;
               if (sum_x > MAX_X) begin
                  next_x = MAX_X;
                  edge_d = 1'b1;
               end else begin
                  next_x = sum_x;
               end
            end else if (amt_x > idx_x) begin
               next_x = '0;
               edge_d = 1'b1;
            end else begin
               next_x = idx_x - amt_x;
            end
         end
      end

      idx_d = next_x[IDX_W-1:0];
      out_d = OUT_W'(1) << idx_d;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         idx      <= RST_I;
         out      <= RST_OH;
         edge_hit <= 1'b0;
         bad_idx  <= 1'b0;
      end else begin
         idx      <= idx_d;
         out      <= out_d;
         edge_hit <= edge_d;
         bad_idx  <= bad_d;
      end
   end

endmodule
